// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU: single-cycle logic/shift/add ops plus
// a sequential radix-2 multiplier and restoring unsigned divider.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             op_start,
    input  logic             op_clear,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       op_state,
    output logic             div_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_NOTA = 4'h0, OP_NOTB = 4'h1, OP_AND  = 4'h2,
                           OP_OR   = 4'h3, OP_XOR  = 4'h4, OP_XNOR = 4'h5,
                           OP_SLT  = 4'h6, OP_SGT  = 4'h7, OP_LSL  = 4'h8,
                           OP_LSR  = 4'h9, OP_ASR  = 4'hA, OP_ADD  = 4'hB,
                           OP_SUB  = 4'hC, OP_MUL  = 4'hD, OP_DIV  = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d;
    logic                 dz_q, dz_d;

    // Single-cycle datapath, computed straight from the live inputs
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] sc_lo, sc_hi;

    always_comb begin
        shamt = b[SHW-1:0];
        add_w = {1'b0, a} + {1'b0, b};
        sc_lo = '0;
        sc_hi = '0;
        case (opcode)
            OP_NOTA: sc_lo = ~a;
            OP_NOTB: sc_lo = ~b;
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_XOR:  sc_lo = a ^ b;
            OP_XNOR: sc_lo = ~(a ^ b);
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SGT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_LSL:  sc_lo = a << shamt;
            OP_LSR:  sc_lo = a >> shamt;
            OP_ASR:  sc_lo = $signed(a) >>> shamt;
            OP_ADD: begin
                sc_lo = add_w[WIDTH-1:0];
                sc_hi = {{(WIDTH-1){1'b0}}, add_w[WIDTH]};
            end
            OP_SUB: begin
                sc_lo = a - b;
                sc_hi = {{(WIDTH-1){1'b0}}, (a < b)};
            end
            default: sc_lo = '0;
        endcase
    end

    // One iteration of either engine; both share acc_q as {hi, lo}.
    // MUL: acc = {partial, multiplier}, shifted right each step.
    // DIV: acc = {remainder, dividend/quotient}, shifted left each step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH:0]     div_r;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] it_nxt;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        div_tmp = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge  = div_tmp >= {1'b0, b_q};
        div_r   = div_ge ? (div_tmp - {1'b0, b_q}) : div_tmp;
        div_nxt = {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        it_nxt  = (op_q == OP_MUL) ? mul_nxt : div_nxt;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dz_d    = dz_q;
        if (op_clear) begin
            state_d = IDLE;
            lo_d    = '0;
            hi_d    = '0;
            dz_d    = 1'b0;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (op_start) begin
                        a_d  = a;
                        b_d  = b;
                        op_d = opcode;
                        dz_d = 1'b0;
                        if (opcode == OP_MUL || (opcode == OP_DIV && b != '0)) begin
                            state_d = EXEC;
                            cnt_d   = '0;
                            acc_d   = (opcode == OP_MUL) ? {{WIDTH{1'b0}}, b}
                                                         : {{WIDTH{1'b0}}, a};
                        end else if (opcode == OP_DIV) begin
                            state_d = DONE;
                            lo_d    = '1;
                            hi_d    = a;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = DONE;
                            lo_d    = sc_lo;
                            hi_d    = sc_hi;
                        end
                    end
                end
                EXEC: begin
                    acc_d = it_nxt;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        lo_d    = it_nxt[WIDTH-1:0];
                        hi_d    = it_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dz_q    <= dz_d;
        end
    end

    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign op_state  = state_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: WIDTH=32 and WIDTH=8 instances checked against an
// arithmetic reference model with directed and random operations.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [31:0] a32, b32, lo32, hi32;
    logic [3:0]  op32;
    logic        st32, cl32, dz32;
    logic [1:0]  s32;

    logic [7:0]  a8, b8, lo8, hi8;
    logic [3:0]  op8;
    logic        st8, cl8, dz8;
    logic [1:0]  s8;

    int errors = 0;
    int checks = 0;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .a(a32), .b(b32), .opcode(op32),
        .op_start(st32), .op_clear(cl32), .result_lo(lo32), .result_hi(hi32),
        .op_state(s32), .div_zero(dz32));

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .a(a8), .b(b8), .opcode(op8),
        .op_start(st8), .op_clear(cl8), .result_lo(lo8), .result_hi(hi8),
        .op_state(s8), .div_zero(dz8));

    // Reference: what the operation means arithmetically, for WIDTH=32
    function automatic void ref32(input logic [3:0] op, input logic [31:0] x, y,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic dz);
        logic [63:0] p;
        lo = 32'd0; hi = 32'd0; dz = 1'b0;
        case (op)
            4'h0: lo = ~x;
            4'h1: lo = ~y;
            4'h2: lo = x & y;
            4'h3: lo = x | y;
            4'h4: lo = x ^ y;
            4'h5: lo = ~(x ^ y);
            4'h6: lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h7: lo = ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
            4'h8: lo = x << y[4:0];
            4'h9: lo = x >> y[4:0];
            4'hA: lo = $signed(x) >>> y[4:0];
            4'hB: begin
                p = 64'(x) + 64'(y);
                lo = p[31:0]; hi = (p > 64'hFFFF_FFFF) ? 32'd1 : 32'd0;
            end
            4'hC: begin lo = x - y; hi = (x < y) ? 32'd1 : 32'd0; end
            4'hD: begin p = 64'(x) * 64'(y); lo = p[31:0]; hi = p[63:32]; end
            4'hE: begin
                if (y == 0) begin lo = 32'hFFFF_FFFF; hi = x; dz = 1'b1; end
                else begin lo = x / y; hi = x % y; end
            end
            default: lo = 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start32(input logic [3:0] op, input logic [31:0] x, y);
        op32 = op; a32 = x; b32 = y; st32 = 1'b1;
        step();
        st32 = 1'b0;
    endtask

    task automatic start8(input logic [3:0] op, input logic [7:0] x, y);
        op8 = op; a8 = x; b8 = y; st8 = 1'b1;
        step();
        st8 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a32 = '0; b32 = '0; op32 = '0; st32 = 0; cl32 = 0;
        a8 = '0;  b8 = '0;  op8 = '0;  st8 = 0;  cl8 = 0;
        #12;
        checks++; if ({s32, lo32, hi32, dz32} !== '0) begin errors++;
            $display("FAIL reset32 got st=%0d lo=%h hi=%h dz=%b want all 0", s32, lo32, hi32, dz32); end
        checks++; if ({s8, lo8, hi8, dz8} !== '0) begin errors++;
            $display("FAIL reset8 got st=%0d lo=%h hi=%h dz=%b want all 0", s8, lo8, hi8, dz8); end
        @(negedge clk); reset_n = 1'b1;
        step(); step();
        checks++; if ({s32, lo32} !== '0) begin errors++;
            $display("FAIL idle_hold got st=%0d lo=%h want 0", s32, lo32); end
    endtask

    task automatic test_and();
        start32(4'h2, 32'h0000_1000, 32'h0010_1000);
        checks++; if ({s32, lo32, hi32} !== {2'b10, 32'h0000_1000, 32'h0}) begin errors++;
            $display("FAIL and got st=%0d lo=%h hi=%h want 2 00001000 0", s32, lo32, hi32); end
    endtask

    task automatic test_single_random();
        logic [3:0] op; logic [31:0] x, y, elo, ehi; logic edz;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            x = $urandom; y = $urandom;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 40);
            if ($urandom_range(0, 5) == 0) x = y;
            if (op == 4'hD) op = 4'hF;
            if (op == 4'hE) y = 32'd0;
            ref32(op, x, y, elo, ehi, edz);
            start32(op, x, y);
            checks++; if ({s32, lo32, hi32, dz32} !== {2'b10, elo, ehi, edz}) begin errors++;
                $display("FAIL single op=%h a=%h b=%h got st=%0d lo=%h hi=%h dz=%b want 2 %h %h %b",
                         op, x, y, s32, lo32, hi32, dz32, elo, ehi, edz); end
        end
    endtask

    task automatic test_mul();
        start32(4'hB, 32'd5, 32'd6);
        start32(4'hD, 32'h0000_1000, 32'h0010_1000);
        checks++; if (s32 !== 2'b01) begin errors++;
            $display("FAIL mul_accept got st=%0d want 1", s32); end
        for (int i = 1; i <= 32; i++) begin
            if (i == 3) begin a32 = $urandom; b32 = $urandom; st32 = 1'b1; op32 = 4'h2; end
            step();
            if (i == 1) begin
                checks++; if ({lo32, hi32} !== {32'd11, 32'd0}) begin errors++;
                    $display("FAIL mul_hold got lo=%h hi=%h want 0000000b 0", lo32, hi32); end
            end
            checks++; if (s32 !== ((i < 32) ? 2'b01 : 2'b10)) begin errors++;
                $display("FAIL mul_state edge=%0d got %0d want %0d", i, s32, (i < 32) ? 1 : 2); end
        end
        st32 = 1'b0;
        checks++; if ({hi32, lo32} !== {32'h0000_0001, 32'h0100_0000}) begin errors++;
            $display("FAIL mul_result got hi=%h lo=%h want 00000001 01000000", hi32, lo32); end
    endtask

    task automatic test_div();
        int n;
        start32(4'hE, 32'd100, 32'd7);
        n = 0;
        while (s32 !== 2'b10 && n < 40) begin step(); n++; end
        checks++; if (n !== 32) begin errors++;
            $display("FAIL div_latency got %0d edges want 32", n); end
        checks++; if ({lo32, hi32, dz32} !== {32'd14, 32'd2, 1'b0}) begin errors++;
            $display("FAIL div_result got lo=%0d hi=%0d dz=%b want 14 2 0", lo32, hi32, dz32); end
        start32(4'hE, 32'd100, 32'd0);
        checks++; if ({s32, lo32, hi32, dz32} !== {2'b10, 32'hFFFF_FFFF, 32'd100, 1'b1}) begin errors++;
            $display("FAIL div_zero got st=%0d lo=%h hi=%0d dz=%b want 2 ffffffff 100 1", s32, lo32, hi32, dz32); end
        start32(4'h2, 32'd3, 32'd1);
        checks++; if ({lo32, dz32} !== {32'd1, 1'b0}) begin errors++;
            $display("FAIL dz_clear got lo=%h dz=%b want 1 0", lo32, dz32); end
    endtask

    task automatic test_add_asr();
        start32(4'hB, 32'hFFFF_FFFF, 32'd1);
        checks++; if ({lo32, hi32} !== {32'd0, 32'd1}) begin errors++;
            $display("FAIL add_carry got lo=%h hi=%h want 0 1", lo32, hi32); end
        start32(4'hA, 32'h8000_0000, 32'd4);
        checks++; if ({lo32, hi32} !== {32'hF800_0000, 32'd0}) begin errors++;
            $display("FAIL asr got lo=%h hi=%h want f8000000 0", lo32, hi32); end
    endtask

    task automatic test_clear_abort();
        start32(4'hD, 32'h1234, 32'h5678);
        for (int i = 1; i <= 9; i++) step();
        cl32 = 1'b1; st32 = 1'b1; op32 = 4'h3; a32 = 32'hA5A5_A5A5; b32 = 32'h1;
        step();
        cl32 = 1'b0; st32 = 1'b0;
        checks++; if ({s32, lo32, hi32, dz32} !== '0) begin errors++;
            $display("FAIL clear got st=%0d lo=%h hi=%h dz=%b want all 0", s32, lo32, hi32, dz32); end
        for (int i = 0; i < 40; i++) step();
        checks++; if ({s32, lo32, hi32} !== '0) begin errors++;
            $display("FAIL clear_drop got st=%0d lo=%h hi=%h want all 0", s32, lo32, hi32); end
    endtask

    task automatic test_random_multi();
        logic [3:0] op; logic [31:0] x, y, elo, ehi; logic edz; int n;
        for (int i = 0; i < 8; i++) begin
            op = (i % 2 == 0) ? 4'hD : 4'hE;
            x = $urandom; y = $urandom;
            if (i >= 4) y = $urandom_range(1, 300);
            if (y == 0) y = 32'd1;
            ref32(op, x, y, elo, ehi, edz);
            start32(op, x, y);
            n = 0;
            while (s32 !== 2'b10 && n < 40) begin a32 = $urandom; b32 = $urandom; step(); n++; end
            checks++; if ({n[7:0], lo32, hi32, dz32} !== {8'd32, elo, ehi, edz}) begin errors++;
                $display("FAIL multi op=%h a=%h b=%h got n=%0d lo=%h hi=%h dz=%b want 32 %h %h %b",
                         op, x, y, n, lo32, hi32, dz32, elo, ehi, edz); end
        end
    endtask

    task automatic test_reset_mid_div();
        start32(4'hB, 32'd7, 32'd9);
        start32(4'hE, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) step();
        checks++; if ({s32, lo32} !== {2'b01, 32'd16}) begin errors++;
            $display("FAIL pre_reset got st=%0d lo=%0d want 1 16", s32, lo32); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({s32, lo32, hi32, dz32} !== '0) begin errors++;
            $display("FAIL async_reset got st=%0d lo=%h hi=%h dz=%b want all 0", s32, lo32, hi32, dz32); end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        checks++; if ({s32, lo32} !== '0) begin errors++;
            $display("FAIL post_reset got st=%0d lo=%h want 0", s32, lo32); end
    endtask

    task automatic test_w8();
        logic [7:0] x, y; logic [15:0] p; int n;
        start8(4'hD, 8'hFF, 8'hFF);
        n = 0;
        while (s8 !== 2'b10 && n < 20) begin step(); n++; end
        checks++; if ({n[7:0], hi8, lo8} !== {8'd8, 8'hFE, 8'h01}) begin errors++;
            $display("FAIL w8_mul got n=%0d hi=%h lo=%h want 8 fe 01", n, hi8, lo8); end
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom); y = 8'($urandom_range(1, 255));
            if (i % 2 == 0) begin
                p = 16'(x) * 16'(y);
                start8(4'hD, x, y);
            end else begin
                p = {8'(x % y), 8'(x / y)};
                start8(4'hE, x, y);
            end
            n = 0;
            while (s8 !== 2'b10 && n < 20) begin step(); n++; end
            checks++; if ({n[7:0], hi8, lo8} !== {8'd8, p}) begin errors++;
                $display("FAIL w8_rand i=%0d a=%h b=%h got n=%0d hi=%h lo=%h want 8 %h", i, x, y, n, hi8, lo8, p); end
        end
        start8(4'h8, 8'h81, 8'd9);
        checks++; if ({lo8, hi8} !== {8'h02, 8'h00}) begin errors++;
            $display("FAIL w8_lsl got lo=%h hi=%h want 02 00", lo8, hi8); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_single_random();
        test_mul();
        test_div();
        test_add_asr();
        test_clear_abort();
        test_random_multi();
        test_reset_mid_div();
        test_w8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the fixed 32-bit ALU with multiplier.
- Adds a configurable datapath width and a sequential unsigned divider alongside the sequential multiplier.
- Uses a simplified start/clear/state handshake, and registers all results.
- Sits as the execution unit under a sequencer that issues one operation at a time and polls op_state.

Parameters:
- WIDTH, 32, datapath width in bits. Must be a power of two and ≥4. The shift amount is b[$clog2(WIDTH)-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- opcode  input  4  operation select
- op_start  input  1  start request; sampled on rising edge
- op_clear  input  1  clear/abort; sampled on rising edge
- result_lo  output  WIDTH  primary result, registered
- result_hi  output  WIDTH  secondary result (MUL high half, DIV remainder, ADD/SUB carry), registered
- op_state  output  2  00 IDLE, 01 EXEC, 10 DONE (11 never driven)
- div_zero  output  1  last DIV had b==0, registered

Behaviour:
- Reset (reset_n=0, async): op_state=IDLE, result_lo=0, result_hi=0, div_zero=0, iteration counter=0, internal operand/accumulator registers=0.
- Opcodes, single-cycle:
  - 0 ~a; 1 ~b; 2 a&b; 3 a|b; 4 a^b; 5 ~(a^b).
  - 6 signed a<b → 1 else 0; 7 signed a>b → 1 else 0.
  - 8 LSL; 9 LSR; A ASR. Shift amount is b[$clog2(WIDTH)-1:0].
  - B ADD: result_lo=sum, result_hi={0..,carry}.
  - C SUB: result_lo=a-b, result_hi={0..,borrow}, where borrow = a<b unsigned.
  - F reserved: result 0.
  - For all single-cycle ops except B/C, result_hi=0.
- Opcodes, multi-cycle:
  - D MUL: unsigned, radix-2 shift-add, {result_hi,result_lo}=a*b.
  - E DIV: unsigned restoring; result_lo=quotient, result_hi=remainder.
- Acceptance: op_start=1 and op_clear=0 at an edge while op_state is IDLE or DONE latches a, b and opcode. div_zero is cleared at acceptance unless the op is DIV with b==0.
- Single-cycle op: on the accepting edge, results are written and op_state→DONE (latency 1).
- MUL/DIV with b≠0: on the accepting edge, op_state→EXEC, counter=0, result_lo and result_hi hold their old values.
  - Each EXEC edge performs one iteration.
  - On the WIDTH-th EXEC edge, results are written and op_state→DONE.
  - DONE is visible exactly WIDTH+1 edges after the accepting edge is counted as edge 0 → WIDTH edges after acceptance.
- DIV with b==0: completes as a single-cycle op. result_lo=all ones, result_hi=a, div_zero=1.
- EXEC: op_start is ignored. Operand and opcode input changes are ignored; the latched copies are used.
- op_clear=1 at an edge in any state: op_state→IDLE, result_lo=0, result_hi=0, div_zero=0. An op in EXEC is aborted with no partial result exposed.
- op_clear has priority over a simultaneous op_start; the start is dropped.
- DONE: results and div_zero hold until op_clear or a new op_start. op_start in DONE is accepted directly (back-to-back, no IDLE cycle required).
- IDLE with neither op_start nor op_clear: all outputs hold.
- Reset asserted mid-EXEC: immediate return to reset values, with no completion.
- Counter width is $clog2(WIDTH)+1. The counter never wraps within an op.

Test Plan:
- WIDTH=32, reset then op_start, opcode=2, a=0x0000_1000, b=0x0010_1000 → next edge: op_state=10, result_lo=0x0000_1000, result_hi=0.
- opcode=D, a=0x0000_1000, b=0x0010_1000; change a/b during EXEC → op_state=01 for 31 edges then 10 on the 32nd edge after acceptance; result_hi=0x0000_0001, result_lo=0x0100_0000.
- opcode=E, a=100, b=7 → DONE after 32 edges, result_lo=14, result_hi=2, div_zero=0. Then opcode=E, b=0 issued from DONE → next edge: result_lo=0xFFFF_FFFF, result_hi=100, div_zero=1.
- opcode=B, a=0xFFFF_FFFF, b=1 → result_lo=0, result_hi=1. Then opcode=A, a=0x8000_0000, b=4 → result_lo=0xF800_0000.
- Start MUL, assert op_clear together with op_start on the 10th EXEC edge → op_state=00, results 0; the dropped start is never executed. Pulse reset_n low mid-DIV → all outputs 0 asynchronously.
- WIDTH=8: opcode=D, a=0xFF, b=0xFF → DONE after 8 edges, result_hi=0xFE, result_lo=0x01.
